mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported backing memory (line-wide rdy/val request/response) between the core's IMEM fetch
//  port and DMEM load/store port. Sits between core and memory, in place of direct dual-port wiring.
//  Holds one outstanding transaction; packs DMEM words into memory lines; drops stale fetches on redirect.
// PARAMETERS
//  ADDR_W      32  byte address width
//  DATA_W      32  DMEM word width
//  LINE_W      64  memory/fetch line width (FETCH_WIDTH*CPU_INST_BITS); power-of-2 multiple of DATA_W
//  TAG_W       6   DMEM transaction tag width, returned unchanged with load data
//  MAX_STARVE  4   consecutive DMEM grants allowed while IMEM waits
// PORTS
//  clk            in   1        clock
//  rst            in   1        async reset, active-high
//  imem_req_val / imem_req_rdy     in/out  1/1     fetch request handshake
//  imem_req_addr  in   ADDR_W   fetch byte address
//  imem_flush     in   1        redirect: discard in-flight fetch
//  imem_rsp_val / imem_rsp_rdy     out/in  1/1     fetch response handshake
//  imem_rsp_data  out  LINE_W   fetched line
//  dmem_req_val / dmem_req_rdy     in/out  1/1     load/store request handshake
//  dmem_req_addr  in   ADDR_W   word address (addr[1:0] ignored)
//  dmem_req_we    in   1        1=store
//  dmem_req_wstrb in   DATA_W/8 byte strobes
//  dmem_req_wdata in   DATA_W   store data
//  dmem_req_tag   in   TAG_W    load tag
//  dmem_rsp_val / dmem_rsp_rdy     out/in  1/1     load response handshake (loads only)
//  dmem_rsp_data / dmem_rsp_tag    out  DATA_W/TAG_W  load word, echoed tag
//  mem_req_val / mem_req_rdy       out/in  1/1     memory request handshake
//  mem_req_addr   out  ADDR_W   line-aligned address
//  mem_req_we     out  1        write
//  mem_req_wstrb  out  LINE_W/8 lane-shifted strobes
//  mem_req_wdata  out  LINE_W   store word replicated across lanes
//  mem_rsp_val / mem_rsp_rdy       in/out  1/1     memory response (one per request, writes included)
//  mem_rsp_data   in   LINE_W   read line
//  perf_imem_grants, perf_dmem_grants, perf_starve_cycles  out 32 each  counters (see CONFIGURATION)
// BEHAVIOUR
//  One clock, clk; reset is asynchronous and active-high on rst.
//  Reset: state=IDLE; all *_val, *_rdy outputs 0; data/tag outputs 0; starve count 0; drop flag 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; write goes WAIT -> IDLE (ack swallowed, no dmem_rsp).
//  IDLE: grant combinationally; winner's req_rdy=1 for that cycle; request latched on val&rdy; -> ISSUE.
//   Priority DMEM > IMEM; IMEM wins if starve_cnt==MAX_STARVE and imem_req_val.
//   starve_cnt++ on DMEM grant while imem_req_val=1 (saturating); cleared on IMEM grant or imem_req_val=0.
//   imem_req_rdy=0 in any cycle imem_flush=1.
//  ISSUE: mem_req_val=1, fields stable from latch; -> WAIT on mem_req_rdy.
//  WAIT: mem_rsp_rdy=1; on mem_rsp_val capture line; read -> RESP, write -> IDLE.
//  RESP: owner's rsp_val=1 until rsp_rdy; -> IDLE on handshake. Requests are never accepted outside IDLE.
//  Latency: accept T -> mem_req_val T+1; memory rsp at cycle R -> requester rsp_val at R+1.
//  Lanes: L=LINE_W/DATA_W; lane=addr[log2(LINE_W/8)-1:2]; mem_req_addr=addr with low log2(LINE_W/8) bits 0;
//   wstrb shifted to lane*DATA_W/8; rsp word=line[lane*DATA_W +: DATA_W]. IMEM addr aligned the same way.
//  Flush: IMEM-owned txn in ISSUE/WAIT sets drop flag; memory response still consumed, then -> IDLE,
//   no imem_rsp_val. In RESP: imem_rsp_val deasserts next cycle, -> IDLE. In IDLE/DMEM-owned: no effect.
//  Reset mid-transaction: immediate return to IDLE; memory shares rst, so no stale response is expected.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: perf_* count IMEM grants, DMEM grants, cycles with imem_req_val=1 & not granted;
//   32-bit wrapping, reset 0. Undefined: perf_* tied 0, no counter flops; port list unchanged.
// STRUCTURE
//  uarch_pkg: arb_state_e {IDLE,ISSUE,WAIT,RESP}, arb_owner_e {OWN_IMEM,OWN_DMEM}, mem_line_req_t
//   {addr,we,wstrb,wdata}.
//  Sub-module mem_arb_lane_pack: combinational word<->line packing (strobe shift, replicate, extract).
//  FSM, starve counter, drop flag, perf counters inline.
// TESTING
//  Reset mid-ISSUE with mem_req_rdy=0 -> next cycle all val=0, state IDLE, imem_req_rdy follows grant rules.
//  IMEM fetch 0x104, mem returns 0x1111_2222_3333_4444 after 2 cycles -> mem_req_addr=0x100, imem_rsp_data equals line.
//  DMEM store addr 0x0C, wstrb 4'b0011, wdata 0xAABBCCDD -> mem wstrb 8'b0011_0000, wdata replicated; no dmem_rsp_val.
//  DMEM load 0x08 tag 5, line 0xDEAD_BEEF_0123_4567 -> dmem_rsp_data 0x01234567, tag 5.
//  DMEM and IMEM both request continuously -> after 4 DMEM grants, IMEM granted; pattern repeats (4:1).
//  imem_flush during WAIT -> response consumed, imem_rsp_val never 1; pending DMEM granted next IDLE cycle.

Source files
------------

// File: rtl/uarch_pkg.sv
// Shared types for the memory port arbiter: FSM states, transaction owner and the latched
// line-wide memory request.
package uarch_pkg;

    localparam int unsigned ARB_ADDR_W     = 32;
    localparam int unsigned ARB_DATA_W     = 32;
    localparam int unsigned ARB_LINE_W     = 64;
    localparam int unsigned ARB_TAG_W      = 6;
    localparam int unsigned ARB_MAX_STARVE = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IMEM,
        OWN_DMEM
    } arb_owner_e;

    // Sized from the package widths; the arbiter's parameters must match these.
    typedef struct packed {
        logic [ARB_ADDR_W-1:0]   addr;
        logic                    we;
        logic [ARB_LINE_W/8-1:0] wstrb;
        logic [ARB_LINE_W-1:0]   wdata;
    } mem_line_req_t;

endpackage

// File: rtl/mem_arb_lane_pack.sv
// Combinational word<->line packing: line-aligns the address, shifts byte strobes into the
// addressed lane, replicates store data and extracts the addressed word from a read line.
module mem_arb_lane_pack #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINE_W = 64
) (
    input  logic [ADDR_W-1:0]              req_addr_i,
    input  logic [DATA_W/8-1:0]            req_wstrb_i,
    input  logic [DATA_W-1:0]              req_wdata_i,
    output logic [ADDR_W-1:0]              line_addr_o,
    output logic [LINE_W/8-1:0]            line_wstrb_o,
    output logic [LINE_W-1:0]              line_wdata_o,
    output logic [$clog2(LINE_W/8)-1:0]    lane_o,
    input  logic [$clog2(LINE_W/8)-1:0]    rsp_lane_i,
    input  logic [LINE_W-1:0]              rsp_line_i,
    output logic [DATA_W-1:0]              rsp_word_o
);

    localparam int unsigned OFF_W  = $clog2(LINE_W / 8);
    localparam int unsigned WOFF_W = $clog2(DATA_W / 8);
    localparam int unsigned WBYTES = DATA_W / 8;
    localparam int unsigned LANES  = LINE_W / DATA_W;

    assign line_addr_o  = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign lane_o       = req_addr_i[OFF_W-1:0] >> WOFF_W;
    assign line_wdata_o = {LANES{req_wdata_i}};

    // Constant-index loops keep the lane muxes free of variable part-selects.
    always_comb begin
        line_wstrb_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_o == OFF_W'(i)) begin
                line_wstrb_o[i*WBYTES +: WBYTES] = req_wstrb_i;
            end
        end
    end

    always_comb begin
        rsp_word_o = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (rsp_lane_i == OFF_W'(i)) begin
                rsp_word_o = rsp_line_i[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported line-wide memory between the IMEM fetch and DMEM load/store ports,
// one outstanding transaction at a time. Define MEM_ARB_PERF_EN to build the perf counters.
module mem_port_arbiter
    import uarch_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned DATA_W     = ARB_DATA_W,
    parameter int unsigned LINE_W     = ARB_LINE_W,
    parameter int unsigned TAG_W      = ARB_TAG_W,
    parameter int unsigned MAX_STARVE = ARB_MAX_STARVE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                imem_req_val_i,
    output logic                imem_req_rdy_o,
    input  logic [ADDR_W-1:0]   imem_req_addr_i,
    input  logic                imem_flush_i,
    output logic                imem_rsp_val_o,
    input  logic                imem_rsp_rdy_i,
    output logic [LINE_W-1:0]   imem_rsp_data_o,
    input  logic                dmem_req_val_i,
    output logic                dmem_req_rdy_o,
    input  logic [ADDR_W-1:0]   dmem_req_addr_i,
    input  logic                dmem_req_we_i,
    input  logic [DATA_W/8-1:0] dmem_req_wstrb_i,
    input  logic [DATA_W-1:0]   dmem_req_wdata_i,
    input  logic [TAG_W-1:0]    dmem_req_tag_i,
    output logic                dmem_rsp_val_o,
    input  logic                dmem_rsp_rdy_i,
    output logic [DATA_W-1:0]   dmem_rsp_data_o,
    output logic [TAG_W-1:0]    dmem_rsp_tag_o,
    output logic                mem_req_val_o,
    input  logic                mem_req_rdy_i,
    output logic [ADDR_W-1:0]   mem_req_addr_o,
    output logic                mem_req_we_o,
    output logic [LINE_W/8-1:0] mem_req_wstrb_o,
    output logic [LINE_W-1:0]   mem_req_wdata_o,
    input  logic                mem_rsp_val_i,
    output logic                mem_rsp_rdy_o,
    input  logic [LINE_W-1:0]   mem_rsp_data_i,
    output logic [31:0]         perf_imem_grants_o,
    output logic [31:0]         perf_dmem_grants_o,
    output logic [31:0]         perf_starve_cycles_o
);

    localparam int unsigned OFF_W = $clog2(LINE_W / 8);
    localparam int unsigned CNT_W = $clog2(MAX_STARVE + 1);

    arb_state_e          state_q, state_d;
    arb_owner_e          owner_q, owner_d;
    mem_line_req_t       req_q, req_d;
    logic [OFF_W-1:0]    lane_q, lane_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                drop_q, drop_d;
    logic [CNT_W-1:0]    starve_q, starve_d;

    logic                imem_elig, force_imem, grant_imem, grant_dmem;
    logic                acc_imem, acc_dmem, is_idle, sel_store, imem_owned;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W/8-1:0] sel_wstrb;
    logic [DATA_W-1:0]   sel_wdata;
    logic [ADDR_W-1:0]   pk_addr;
    logic [LINE_W/8-1:0] pk_wstrb;
    logic [LINE_W-1:0]   pk_wdata;
    logic [OFF_W-1:0]    pk_lane;
    logic [DATA_W-1:0]   rsp_word;

    // DMEM has priority unless IMEM has been passed over MAX_STARVE times in a row.
    assign is_idle    = (state_q == IDLE);
    assign imem_elig  = imem_req_val_i & ~imem_flush_i;
    assign force_imem = imem_elig & (starve_q == CNT_W'(MAX_STARVE));
    assign grant_dmem = dmem_req_val_i & ~force_imem;
    assign grant_imem = imem_elig & ~grant_dmem;

    assign imem_req_rdy_o = is_idle & grant_imem;
    assign dmem_req_rdy_o = is_idle & grant_dmem;
    assign acc_imem       = imem_req_rdy_o & imem_req_val_i;
    assign acc_dmem       = dmem_req_rdy_o & dmem_req_val_i;
    assign imem_owned     = (owner_q == OWN_IMEM);

    assign sel_store = grant_dmem & dmem_req_we_i;
    assign sel_addr  = grant_dmem ? dmem_req_addr_i : imem_req_addr_i;
    assign sel_wstrb = sel_store ? dmem_req_wstrb_i : '0;
    assign sel_wdata = sel_store ? dmem_req_wdata_i : '0;

    mem_arb_lane_pack #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LINE_W (LINE_W)
    ) u_lane_pack (
        .req_addr_i   (sel_addr),
        .req_wstrb_i  (sel_wstrb),
        .req_wdata_i  (sel_wdata),
        .line_addr_o  (pk_addr),
        .line_wstrb_o (pk_wstrb),
        .line_wdata_o (pk_wdata),
        .lane_o       (pk_lane),
        .rsp_lane_i   (lane_q),
        .rsp_line_i   (line_q),
        .rsp_word_o   (rsp_word)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        req_d   = req_q;
        lane_d  = lane_q;
        tag_d   = tag_q;
        line_d  = line_q;
        drop_d  = drop_q;

        if ((state_q == ISSUE || state_q == WAIT) && imem_owned && imem_flush_i) begin
            drop_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (acc_imem || acc_dmem) begin
                    state_d     = ISSUE;
                    owner_d     = acc_dmem ? OWN_DMEM : OWN_IMEM;
                    req_d.addr  = pk_addr;
                    req_d.we    = sel_store;
                    req_d.wstrb = pk_wstrb;
                    req_d.wdata = pk_wdata;
                    lane_d      = pk_lane;
                    drop_d      = 1'b0;
                    if (acc_dmem) begin
                        tag_d = dmem_req_tag_i;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_rdy_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_val_i) begin
                    line_d = mem_rsp_data_i;
                    drop_d = 1'b0;
                    // Store acks and flushed fetches are absorbed here.
                    if (req_q.we || drop_q || (imem_owned && imem_flush_i)) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (imem_owned) begin
                    if (imem_rsp_rdy_i || imem_flush_i) begin
                        state_d = IDLE;
                    end
                end else if (dmem_rsp_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!imem_req_val_i || acc_imem) begin
            starve_d = '0;
        end else if (acc_dmem && starve_q != CNT_W'(MAX_STARVE)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IMEM;
            req_q    <= '0;
            lane_q   <= '0;
            tag_q    <= '0;
            line_q   <= '0;
            drop_q   <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            lane_q   <= lane_d;
            tag_q    <= tag_d;
            line_q   <= line_d;
            drop_q   <= drop_d;
            starve_q <= starve_d;
        end
    end

    assign mem_req_val_o   = (state_q == ISSUE);
    assign mem_req_addr_o  = req_q.addr;
    assign mem_req_we_o    = req_q.we;
    assign mem_req_wstrb_o = req_q.wstrb;
    assign mem_req_wdata_o = req_q.wdata;
    assign mem_rsp_rdy_o   = (state_q == WAIT);

    assign imem_rsp_val_o  = (state_q == RESP) & imem_owned;
    assign dmem_rsp_val_o  = (state_q == RESP) & ~imem_owned;
    assign imem_rsp_data_o = line_q;
    assign dmem_rsp_data_o = rsp_word;
    assign dmem_rsp_tag_o  = tag_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_imem_q, perf_imem_d;
    logic [31:0] perf_dmem_q, perf_dmem_d;
    logic [31:0] perf_starve_q, perf_starve_d;

    always_comb begin
        perf_imem_d   = perf_imem_q + {31'd0, acc_imem};
        perf_dmem_d   = perf_dmem_q + {31'd0, acc_dmem};
        perf_starve_d = perf_starve_q + {31'd0, imem_req_val_i & ~acc_imem};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_imem_q   <= '0;
            perf_dmem_q   <= '0;
            perf_starve_q <= '0;
        end else begin
            perf_imem_q   <= perf_imem_d;
            perf_dmem_q   <= perf_dmem_d;
            perf_starve_q <= perf_starve_d;
        end
    end

    assign perf_imem_grants_o   = perf_imem_q;
    assign perf_dmem_grants_o   = perf_dmem_q;
    assign perf_starve_cycles_o = perf_starve_q;
`else
    assign perf_imem_grants_o   = '0;
    assign perf_dmem_grants_o   = '0;
    assign perf_starve_cycles_o = '0;
`endif

endmodule
